// File: rtl/lane_reorder_ctrl_if.sv
// Status/control bundle between the alignment/deskew front end and the
// lane-reorder sequencer. The master drives lane status and IDs; the slave
// (the sequencer) returns the reorder-block controls and status.
interface lane_reorder_ctrl_if #(
  parameter int N_LANES   = 20,
  parameter int NB_ID     = $clog2(N_LANES),
  parameter int NB_ID_BUS = N_LANES * NB_ID,
  parameter int NB_RETRY  = 2
);
  logic                 i_enable;
  logic                 i_valid;
  logic [N_LANES-1:0]   i_lane_aligned;
  logic                 i_deskew_done;
  logic [NB_ID_BUS-1:0] i_logical_rx_ID;
  logic                 o_reset_order;
  logic                 o_reorder_enable;
  logic                 o_locked;
  logic                 o_fail;
  logic [2:0]           o_state;
  logic [NB_RETRY-1:0]  o_retry_count;
  logic [7:0]           o_relock_count;

  modport master (
    output i_enable, i_valid, i_lane_aligned, i_deskew_done, i_logical_rx_ID,
    input  o_reset_order, o_reorder_enable, o_locked, o_fail, o_state,
           o_retry_count, o_relock_count
  );

  modport slave (
    input  i_enable, i_valid, i_lane_aligned, i_deskew_done, i_logical_rx_ID,
    output o_reset_order, o_reorder_enable, o_locked, o_fail, o_state,
           o_retry_count, o_relock_count
  );
endinterface

// File: rtl/lane_reorder_ctrl.sv
// RX lane-reorder sequencer: waits for alignment and deskew, validates the
// logical lane ID permutation, then clears and enables the reorder block for
// exactly N_LANES valid cycles before reporting lock. Bad ID sets are retried
// until MAX_RETRY failures, after which the block parks in FAIL.
module lane_reorder_ctrl #(
  parameter int N_LANES   = 20,
  parameter int NB_ID     = $clog2(N_LANES),
  parameter int NB_ID_BUS = N_LANES * NB_ID,
  parameter int MAX_RETRY = 3,
  parameter int NB_RETRY  = $clog2(MAX_RETRY + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  lane_reorder_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_ALIGN  = 3'd1,
    WAIT_DESKEW = 3'd2,
    REORDER     = 3'd3,
    LOCKED      = 3'd4,
    FAIL        = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [NB_ID-1:0]    lane_cnt_q, lane_cnt_d;
  logic [NB_RETRY-1:0] retry_q, retry_d;
  logic [NB_RETRY-1:0] retry_inc;
  logic [7:0]          relock_q, relock_d;
  logic                reset_order_q, reorder_en_q, locked_q, fail_q;
  logic                all_aligned;
  logic                id_ok;
  logic                link_lost;

  // True when every ID is in range and together they cover every logical lane.
  // Lane 0 occupies the most significant ID slot of the bus.
  function automatic logic ids_are_permutation(input logic [NB_ID_BUS-1:0] ids);
    logic [N_LANES-1:0] seen;
    logic [NB_ID-1:0]   id;
    logic               in_range;
    seen     = '0;
    in_range = 1'b1;
    for (int i = 0; i < N_LANES; i++) begin
      id = ids[(N_LANES-1-i)*NB_ID +: NB_ID];
      if (32'(id) < N_LANES) begin
        seen[id] = 1'b1;
      end else begin
        in_range = 1'b0;
      end
    end
    return in_range && (&seen);
  endfunction

  assign all_aligned = &bus.i_lane_aligned;
  assign id_ok       = ids_are_permutation(bus.i_logical_rx_ID);
  assign link_lost   = !all_aligned || !bus.i_deskew_done;
  assign retry_inc   = retry_q + NB_RETRY'(1);

  // Next-state logic plus lane, retry and relock counter updates.
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    retry_d    = retry_q;
    relock_d   = relock_q;
    if (!bus.i_enable) begin
      state_d    = IDLE;
      lane_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_ALIGN;
        end
        WAIT_ALIGN: begin
          if (all_aligned) begin
            state_d = WAIT_DESKEW;
          end else begin
            state_d = WAIT_ALIGN;
          end
        end
        WAIT_DESKEW: begin
          if (!all_aligned) begin
            state_d = WAIT_ALIGN;
          end else if (bus.i_deskew_done && bus.i_valid) begin
            if (id_ok) begin
              state_d    = REORDER;
              lane_cnt_d = '0;
            end else begin
              retry_d = retry_inc;
              if (retry_inc == NB_RETRY'(MAX_RETRY)) begin
                state_d = FAIL;
              end else begin
                state_d = WAIT_ALIGN;
              end
            end
          end else begin
            state_d = WAIT_DESKEW;
          end
        end
        REORDER: begin
          // Losing alignment/deskew wins over finishing the last lane.
          if (link_lost) begin
            state_d    = WAIT_ALIGN;
            lane_cnt_d = '0;
          end else if (bus.i_valid) begin
            if (lane_cnt_q == NB_ID'(N_LANES - 1)) begin
              state_d    = LOCKED;
              lane_cnt_d = '0;
              retry_d    = '0;
            end else begin
              lane_cnt_d = lane_cnt_q + NB_ID'(1);
            end
          end else begin
            state_d = REORDER;
          end
        end
        LOCKED: begin
          if (link_lost) begin
            state_d = WAIT_ALIGN;
            if (relock_q != 8'd255) begin
              relock_d = relock_q + 8'd1;
            end else begin
              relock_d = relock_q;
            end
          end else begin
            state_d = LOCKED;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    // Any return to IDLE starts a fresh retry budget.
    if (state_d == IDLE) begin
      retry_d = '0;
    end else begin
      retry_d = retry_d;
    end
  end

  // State, counters and Moore outputs; outputs are decoded from the next
  // state so they line up with the registered state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= IDLE;
      lane_cnt_q    <= '0;
      retry_q       <= '0;
      relock_q      <= 8'd0;
      reset_order_q <= 1'b1;
      reorder_en_q  <= 1'b0;
      locked_q      <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_cnt_q    <= lane_cnt_d;
      retry_q       <= retry_d;
      relock_q      <= relock_d;
      reset_order_q <= (state_d == IDLE) || (state_d == WAIT_ALIGN) ||
                       (state_d == WAIT_DESKEW) || (state_d == FAIL);
      reorder_en_q  <= (state_d == REORDER);
      locked_q      <= (state_d == LOCKED);
      fail_q        <= (state_d == FAIL);
    end
  end

  assign bus.o_state          = state_q;
  assign bus.o_reset_order    = reset_order_q;
  assign bus.o_reorder_enable = reorder_en_q;
  assign bus.o_locked         = locked_q;
  assign bus.o_fail           = fail_q;
  assign bus.o_retry_count    = retry_q;
  assign bus.o_relock_count   = relock_q;

endmodule

// File: tb/tb_lane_reorder_ctrl.sv
// Directed bench for lane_reorder_ctrl. Stimulus pushes the expected
// post-edge outputs into a queue; a monitor on the falling edge pops and
// compares them against the DUT.
module tb_lane_reorder_ctrl;
  localparam int N_LANES   = 20;
  localparam int NB_ID     = 5;
  localparam int NB_ID_BUS = N_LANES * NB_ID;
  localparam int NB_RETRY  = 2;

  logic clk;
  logic rst;

  lane_reorder_ctrl_if #(.N_LANES(N_LANES), .NB_ID(NB_ID), .NB_ID_BUS(NB_ID_BUS),
                         .NB_RETRY(NB_RETRY)) bus ();

  lane_reorder_ctrl #(.N_LANES(N_LANES), .NB_ID(NB_ID), .NB_ID_BUS(NB_ID_BUS),
                      .MAX_RETRY(3), .NB_RETRY(NB_RETRY)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [1:0] rt;
    logic [7:0] rl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build the ID bus: lane i carries ID i (lane 0 in MSBs), optionally
  // corrupting lanes 5 and 6 to both carry ID 3.
  function automatic logic [NB_ID_BUS-1:0] make_ids(input bit bad);
    logic [NB_ID_BUS-1:0] b;
    logic [NB_ID-1:0]     id;
    b = '0;
    for (int i = 0; i < N_LANES; i++) begin
      id = NB_ID'(i);
      if (bad && (i == 5 || i == 6)) id = 5'd3;
      b[(N_LANES-1-i)*NB_ID +: NB_ID] = id;
    end
    return b;
  endfunction

  // Queue one expected post-edge snapshot and advance one clock.
  task automatic cyc(input string nm, input logic [2:0] st, input logic [1:0] rt,
                     input logic [7:0] rl);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.rt   = rt;
    e.rl   = rl;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare every queued expectation against the DUT outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic ro, en, lk, fl;
      e  = exp_q.pop_front();
      ro = (e.st == 3'd0) || (e.st == 3'd1) || (e.st == 3'd2) || (e.st == 3'd5);
      en = (e.st == 3'd3);
      lk = (e.st == 3'd4);
      fl = (e.st == 3'd5);
      checks++;
      if (bus.o_state !== e.st || bus.o_reset_order !== ro ||
          bus.o_reorder_enable !== en || bus.o_locked !== lk || bus.o_fail !== fl ||
          bus.o_retry_count !== e.rt || bus.o_relock_count !== e.rl) begin
        errors++;
        $display("FAIL %s t=%0t: got st=%0d ro=%0b en=%0b lk=%0b fl=%0b rt=%0d rl=%0d, want st=%0d ro=%0b en=%0b lk=%0b fl=%0b rt=%0d rl=%0d",
                 e.name, $time, bus.o_state, bus.o_reset_order, bus.o_reorder_enable,
                 bus.o_locked, bus.o_fail, bus.o_retry_count, bus.o_relock_count,
                 e.st, ro, en, lk, fl, e.rt, e.rl);
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst                 = 1'b1;
    bus.i_enable        = 1'b0;
    bus.i_valid         = 1'b1;
    bus.i_lane_aligned  = '1;
    bus.i_deskew_done   = 1'b1;
    bus.i_logical_rx_ID = make_ids(1'b0);

    // Reset state
    cyc("reset", 3'd0, 2'd0, 8'd0);
    cyc("reset", 3'd0, 2'd0, 8'd0);

    // 1: straight lock with valid every cycle
    rst = 1'b0;
    bus.i_enable = 1'b1;
    cyc("t1_align", 3'd1, 2'd0, 8'd0);
    cyc("t1_deskew", 3'd2, 2'd0, 8'd0);
    repeat (20) cyc("t1_reorder", 3'd3, 2'd0, 8'd0);
    cyc("t1_locked", 3'd4, 2'd0, 8'd0);
    cyc("t1_hold", 3'd4, 2'd0, 8'd0);

    // 2: valid toggling doubles the REORDER dwell
    bus.i_enable = 1'b0;
    cyc("t2_idle", 3'd0, 2'd0, 8'd0);
    bus.i_enable = 1'b1;
    cyc("t2_align", 3'd1, 2'd0, 8'd0);
    cyc("t2_deskew", 3'd2, 2'd0, 8'd0);
    cyc("t2_reorder", 3'd3, 2'd0, 8'd0);
    for (int k = 0; k < 20; k++) begin
      bus.i_valid = 1'b0;
      cyc("t2_reorder_nv", 3'd3, 2'd0, 8'd0);
      bus.i_valid = 1'b1;
      cyc(k == 19 ? "t2_locked" : "t2_reorder_v", (k == 19) ? 3'd4 : 3'd3, 2'd0, 8'd0);
    end

    // 3: duplicate IDs exhaust retries, then recover via enable
    bus.i_enable = 1'b0;
    bus.i_logical_rx_ID = make_ids(1'b1);
    cyc("t3_idle", 3'd0, 2'd0, 8'd0);
    bus.i_enable = 1'b1;
    cyc("t3_align", 3'd1, 2'd0, 8'd0);
    cyc("t3_deskew", 3'd2, 2'd0, 8'd0);
    cyc("t3_retry1", 3'd1, 2'd1, 8'd0);
    cyc("t3_deskew", 3'd2, 2'd1, 8'd0);
    cyc("t3_retry2", 3'd1, 2'd2, 8'd0);
    cyc("t3_deskew", 3'd2, 2'd2, 8'd0);
    cyc("t3_fail", 3'd5, 2'd3, 8'd0);
    cyc("t3_fail_hold", 3'd5, 2'd3, 8'd0);
    bus.i_enable = 1'b0;
    cyc("t3_idle_clr", 3'd0, 2'd0, 8'd0);
    bus.i_enable = 1'b1;
    bus.i_logical_rx_ID = make_ids(1'b0);
    cyc("t3_align", 3'd1, 2'd0, 8'd0);
    cyc("t3_deskew", 3'd2, 2'd0, 8'd0);
    repeat (20) cyc("t3_reorder", 3'd3, 2'd0, 8'd0);
    cyc("t3_locked", 3'd4, 2'd0, 8'd0);

    // 4: single-cycle alignment drop while locked
    bus.i_lane_aligned[7] = 1'b0;
    cyc("t4_drop", 3'd1, 2'd0, 8'd1);
    bus.i_lane_aligned[7] = 1'b1;
    cyc("t4_deskew", 3'd2, 2'd0, 8'd1);
    repeat (20) cyc("t4_reorder", 3'd3, 2'd0, 8'd1);
    cyc("t4_locked", 3'd4, 2'd0, 8'd1);

    // 5: deskew lost at lane count 10 restarts the full count
    bus.i_lane_aligned[0] = 1'b0;
    cyc("t5_drop", 3'd1, 2'd0, 8'd2);
    bus.i_lane_aligned[0] = 1'b1;
    cyc("t5_deskew", 3'd2, 2'd0, 8'd2);
    repeat (11) cyc("t5_reorder", 3'd3, 2'd0, 8'd2);
    bus.i_deskew_done = 1'b0;
    cyc("t5_lost", 3'd1, 2'd0, 8'd2);
    bus.i_deskew_done = 1'b1;
    cyc("t5_deskew", 3'd2, 2'd0, 8'd2);
    repeat (20) cyc("t5_reorder_full", 3'd3, 2'd0, 8'd2);
    cyc("t5_locked", 3'd4, 2'd0, 8'd2);

    // Loss on the final lane beats completion
    bus.i_lane_aligned[19] = 1'b0;
    cyc("t7_drop", 3'd1, 2'd0, 8'd3);
    bus.i_lane_aligned[19] = 1'b1;
    cyc("t7_deskew", 3'd2, 2'd0, 8'd3);
    repeat (20) cyc("t7_reorder", 3'd3, 2'd0, 8'd3);
    bus.i_deskew_done = 1'b0;
    cyc("t7_loss_wins", 3'd1, 2'd0, 8'd3);
    bus.i_deskew_done = 1'b1;
    cyc("t7_deskew", 3'd2, 2'd0, 8'd3);
    repeat (20) cyc("t7_reorder", 3'd3, 2'd0, 8'd3);
    cyc("t7_locked", 3'd4, 2'd0, 8'd3);

    // 6: synchronous reset mid-REORDER, then relock counter saturation
    bus.i_lane_aligned[3] = 1'b0;
    cyc("t6_drop", 3'd1, 2'd0, 8'd4);
    bus.i_lane_aligned[3] = 1'b1;
    cyc("t6_deskew", 3'd2, 2'd0, 8'd4);
    repeat (5) cyc("t6_reorder", 3'd3, 2'd0, 8'd4);
    rst = 1'b1;
    cyc("t6_reset", 3'd0, 2'd0, 8'd0);
    rst = 1'b0;
    cyc("t6_align", 3'd1, 2'd0, 8'd0);
    cyc("t6_deskew", 3'd2, 2'd0, 8'd0);
    repeat (20) cyc("t6_reorder", 3'd3, 2'd0, 8'd0);
    cyc("t6_locked", 3'd4, 2'd0, 8'd0);
    for (int n = 1; n <= 256; n++) begin
      logic [7:0] want;
      want = (n > 255) ? 8'd255 : 8'(n);
      bus.i_lane_aligned[11] = 1'b0;
      cyc("t6_sat_drop", 3'd1, 2'd0, want);
      bus.i_lane_aligned[11] = 1'b1;
      cyc("t6_sat_deskew", 3'd2, 2'd0, want);
      repeat (20) cyc("t6_sat_reorder", 3'd3, 2'd0, want);
      cyc("t6_sat_locked", 3'd4, 2'd0, want);
    end

    // Let the monitor drain the queue
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
